// File: rtl/ysyx_20020207_wb_pkg.sv
// ysyx_20020207_wb_pkg: shared constants, FSM state and wb stage record for alu_writeback
package ysyx_20020207_wb_pkg;
    localparam int XLEN        = 32;
    localparam int REG_NUM     = 32;
    localparam int AW          = $clog2(REG_NUM);
    localparam int INIT_CYCLES = 32;

    typedef enum logic {WB_INIT, WB_RUN} wb_state_t;

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_stage_t;

    // one-hot select of a register; x0 never selects anything
    function automatic logic [REG_NUM-1:0] reg_bit(input logic [AW-1:0] a);
        return (a == '0) ? '0 : REG_NUM'(1) << a;
    endfunction
endpackage

// File: rtl/ysyx_20020207_regfile.sv
// ysyx_20020207_regfile: 32x32 register array, one write port, two async read ports, x0 reads zero
module ysyx_20020207_regfile
    import ysyx_20020207_wb_pkg::*;
(
    input  logic            clock,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    logic [XLEN-1:0] mem [REG_NUM];

    // array has no reset; contents are cleared only by the owner's sweep
    always_ff @(posedge clock)
        if (we) mem[waddr] <= wdata;

    assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: ALU result writeback stage with register file, busy scoreboard and retire counter (optional WB_BYPASS_EN forwards the wb stage to the read ports)
module alu_writeback
    import ysyx_20020207_wb_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] result,
    input  logic            reg_wen,
    input  logic [AW-1:0]   reg_addr,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            claim_valid,
    input  logic [AW-1:0]   claim_addr,
    output logic            retire,
    output logic [31:0]     retire_count
);
    wb_state_t          state;
    logic [AW-1:0]      sweep;
    wb_stage_t          wb;
    logic [REG_NUM-1:0] busy, claim_set, wb_clr;
    logic               run, rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [XLEN-1:0]    rf_wdata, rf_rdata1, rf_rdata2;

    assign run       = state == WB_RUN;
    assign in_ready  = run;
    assign rf_we     = !run || (wb.valid && wb.wen && wb.addr != '0);
    assign rf_waddr  = run ? wb.addr : sweep;
    assign rf_wdata  = run ? wb.data : '0;
    assign claim_set = (run && claim_valid) ? reg_bit(claim_addr) : '0;
    assign wb_clr    = wb.valid ? reg_bit(wb.addr) : '0;

    ysyx_20020207_regfile u_rf (
        .clock  (clock),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // zeroing sweep after reset, then RUN until the next reset
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= WB_INIT;
            sweep <= '0;
        end else if (state == WB_INIT) begin
            sweep <= sweep + 1'b1;
            if (sweep == AW'(INIT_CYCLES - 1)) state <= WB_RUN;
        end

    // wb stage register plus retire pulse and counter
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wb           <= '0;
            retire       <= 1'b0;
            retire_count <= '0;
        end else begin
            wb           <= (in_valid && run) ? {1'b1, reg_wen, reg_addr, result} : '0;
            retire       <= wb.valid;
            retire_count <= retire_count + 32'(wb.valid);
        end

    // scoreboard: a same-cycle claim overrides the writeback clear
    always_ff @(posedge clock or negedge reset)
        if (!reset) busy <= '0;
        else        busy <= (busy & ~wb_clr) | claim_set;

`ifdef WB_BYPASS_EN
    logic wb_fwd;
    assign wb_fwd = wb.valid && wb.wen && wb.addr != '0;
`endif

    // read ports: zero during the sweep, optional forwarding from the wb stage
    always_comb begin
        rs1_data = run ? rf_rdata1 : '0;
        rs2_data = run ? rf_rdata2 : '0;
        rs1_busy = run && busy[rs1_addr];
        rs2_busy = run && busy[rs2_addr];
`ifdef WB_BYPASS_EN
        if (wb_fwd && rs1_addr == wb.addr) begin
            rs1_data = wb.data;
            rs1_busy = claim_set[rs1_addr];
        end
        if (wb_fwd && rs2_addr == wb.addr) begin
            rs2_data = wb.data;
            rs2_busy = claim_set[rs2_addr];
        end
`endif
    end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: scoreboard bench for alu_writeback with a register-array reference model
module tb_alu_writeback;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] result = '0;
    logic        reg_wen = 1'b0;
    logic [4:0]  reg_addr = '0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        claim_valid = 1'b0;
    logic [4:0]  claim_addr = '0;
    logic        retire;
    logic [31:0] retire_count;

    alu_writeback dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .reg_wen(reg_wen), .reg_addr(reg_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .claim_valid(claim_valid),
        .claim_addr(claim_addr), .retire(retire), .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] rd;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rf [32];
    logic [31:0] count = '0;
    bit          prev_beat = 0;
    int          compared = 0, mismatched = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // reference: a beat updates the architectural state in order; the expected
    // readback at retire is the value visible one cycle after the array write,
    // which with forwarding also includes an immediately following beat
    task automatic issue(input bit w, input logic [4:0] a, input logic [31:0] d);
        if (w && a != 0) model_rf[a] = d;
        count++;
`ifdef WB_BYPASS_EN
        if (prev_beat && sb.size() > 0) sb[$].rd = model_rf[sb[$].addr];
`endif
        sb.push_back('{addr: a, rd: model_rf[a], cnt: count});
        prev_beat = 1;
    endtask

    task automatic tick(input bit v, input bit w, input logic [4:0] a, input logic [31:0] d,
                        input bit cv, input logic [4:0] ca);
        in_valid = v; reg_wen = w; reg_addr = a; result = d;
        claim_valid = cv; claim_addr = ca;
        if (v && in_ready) issue(w, a, d);
        else prev_beat = 0;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd2(input string n, input logic [4:0] a, input logic [31:0] exp);
        rs2_addr = a;
        #1 chk(n, rs2_data, exp);
    endtask

    task automatic bz2(input string n, input logic [4:0] a, input bit exp);
        rs2_addr = a;
        #1 chk(n, 32'(rs2_busy), 32'(exp));
    endtask

    // assert reset, check reset state, then run the sweep with in_valid held high
    task automatic do_reset();
        #3 reset = 1'b0;
        sb.delete();
        count = '0;
        prev_beat = 0;
        foreach (model_rf[i]) model_rf[i] = '0;
        in_valid = 1'b1; claim_valid = 1'b0; rs2_addr = 5'd9;
        #1;
        chk("rst_retire", 32'(retire), 0);
        chk("rst_retire_count", retire_count, 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_rs2_data", rs2_data, 0);
        chk("rst_rs2_busy", 32'(rs2_busy), 0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clock);
            chk("sweep_in_ready", 32'(in_ready), 32'(i == 32));
        end
        in_valid = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd2("sweep_zero", 5'(a), 0);
            idle(1);
        end
    endtask

    // monitor: every retire pops one expected beat and checks count and readback
    always @(negedge clock) begin
        if (reset && retire) begin
            if (sb.size() == 0) begin
                chk("retire_unexpected", 32'(retire), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                rs1_addr = e.addr;
                #1;
                chk("retire_count", retire_count, e.cnt);
                chk("retire_readback", rs1_data, e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // basic write
        tick(1, 1, 5, 32'hDEADBEEF, 0, 0);
`ifdef WB_BYPASS_EN
        rd2("basic_e0", 5, 32'hDEADBEEF);
`else
        rd2("basic_e0", 5, 0);
`endif
        idle(1);
        rd2("basic_e1", 5, 32'hDEADBEEF);
        idle(2);
        chk("basic_count", retire_count, 1);

        // x0 and no-write beats
        tick(1, 1, 7, 32'hA5A5_0007, 0, 0);
        tick(1, 1, 0, 32'h1234, 0, 0);
        tick(1, 0, 7, 32'hFFFF_FFFF, 0, 0);
        idle(3);
        rd2("x0_zero", 0, 0);
        rd2("x7_kept", 7, 32'hA5A5_0007);
        chk("x0_count", retire_count, 4);

        // scoreboard set and clear
        tick(0, 0, 0, 0, 1, 9);
        bz2("claim_busy", 9, 1);
        tick(1, 1, 9, 32'h0000_0909, 0, 0);
`ifdef WB_BYPASS_EN
        bz2("busy_e0", 9, 0);
`else
        bz2("busy_e0", 9, 1);
`endif
        idle(1);
        bz2("busy_cleared", 9, 0);
        bz2("busy_x0", 0, 0);

        // claim in the same cycle as the clear
        tick(0, 0, 0, 0, 1, 9);
        tick(1, 1, 9, 32'h0000_0990, 0, 0);
        in_valid = 1'b0; claim_valid = 1'b1; claim_addr = 5'd9; prev_beat = 0;
        bz2("claim_vs_clear_e0", 9, 1);
        @(negedge clock);
        claim_valid = 1'b0;
        bz2("claim_wins", 9, 1);
        tick(1, 0, 9, 0, 0, 0);
        idle(2);
        bz2("busy_released", 9, 0);

        // back-to-back beats to one register
        do_reset();
        tick(1, 1, 3, 1, 0, 0);
        tick(1, 1, 3, 2, 0, 0);
        tick(1, 1, 3, 3, 0, 0);
        idle(3);
        rd2("b2b_x3", 3, 3);
        chk("b2b_count", retire_count, 3);

        // random traffic checked by the monitor
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
        idle(4);
        for (int a = 0; a < 8; a++) rd2("rand_final", 5'(a), model_rf[a]);

        // reset with a beat in the wb stage
        tick(0, 0, 0, 0, 1, 12);
        tick(1, 1, 4, 32'hCAFE_0004, 0, 0);
        do_reset();
        idle(3);
        chk("post_reset_count", retire_count, 0);
        bz2("post_reset_busy", 12, 0);
        rd2("post_reset_x4", 4, 0);

        chk("queue_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage on the consumer side of the ALU valid/ready handshake. It accepts one ALU result beat per cycle and registers it for one cycle, then writes it into a 32×32 integer register file. It serves two operand read ports to issue, and it keeps a per-register busy scoreboard that issue sets and writeback clears. It sits between the ALU and the issue/decode stage and closes the RAW-hazard loop.

## Interface
- XLEN, 32, datapath width
- REG_NUM, 32, architectural registers; x0 is hardwired zero
- INIT_CYCLES, 32, length of the post-reset zeroing sweep
- clock  in  1  single clock; everything is on its rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  ALU result beat valid
- in_ready  out  1  stage can accept a beat
- result  in  XLEN  ALU result
- reg_wen  in  1  beat writes a register
- reg_addr  in  5  destination register
- rs1_addr, rs2_addr  in  5 each  read-port addresses
- rs1_data, rs2_data  out  XLEN each  read data (combinational)
- rs1_busy, rs2_busy  out  1 each  scoreboard state of the addressed register
- claim_valid  in  1  issue claims a destination register
- claim_addr  in  5  register being claimed
- retire  out  1  one-cycle pulse per completed beat
- retire_count  out  32  count of completed beats

## Operation
- FSM states:
  - INIT: after reset, a 5-bit sweep counter runs 0→31 and writes zero to entry[counter], one entry per cycle. On the cycle the counter equals 31, the FSM moves to RUN.
  - RUN: normal operation; it only leaves RUN on reset.
- Output behaviour in INIT:
  - in_ready=0.
  - rs*_data forced to 0.
  - rs*_busy forced to 0.
  - Claims are ignored.
- Output behaviour in RUN:
  - in_ready=1 every cycle; the stage never back-pressures.
  - Accept = in_valid && in_ready. On accept, {result, reg_wen, reg_addr} latch into the wb stage register and wb_valid is set for the next cycle.
  - While wb_valid: if reg_wen && reg_addr!=0, entry[reg_addr] ← result at the next edge.
  - While wb_valid: busy[reg_addr] is cleared at the next edge. A write to x0 or a beat with reg_wen=0 still retires.
- retire = wb_valid, registered. retire_count increments on each retire and wraps 0xFFFFFFFF→0.
- Reads:
  - rs*_data = entry[rs*_addr].
  - Address 0 always returns 0.
  - rs*_busy = busy[rs*_addr]; busy[0] is always 0.
- Scoreboard:
  - claim_valid with claim_addr!=0 sets busy[claim_addr].
  - Claim and clear on the same register in the same cycle: the claim wins and busy stays 1.
  - Claiming an already-busy register leaves it busy; outstanding writers are not counted.

## Timing
- Reset values:
  - State=INIT, counter=0, in_ready=0.
  - wb_valid=0, retire=0, retire_count=0.
  - All busy bits=0, rs*_data=0.
- in_ready first rises 32 cycles after reset deasserts.
- Latency:
  - Beat accepted at edge E0 → array written at E1.
  - retire is high in the cycle after E1.
- Back-to-back beats: one per cycle, no bubbles. A same-address beat in consecutive cycles leaves the later value in the array.
- Reset asserted mid-operation:
  - A pending wb beat is dropped and busy bits clear.
  - The sweep restarts at 0.
  - The array is not cleared asynchronously; it is cleared only by the sweep.

## Configuration
- WB_BYPASS_EN defined:
  - While wb_valid && reg_wen && reg_addr!=0 && rs*_addr==reg_addr, rs*_data returns the wb stage result. The new value is readable from the cycle after E0.
  - rs*_busy for that address also reads 0 in that cycle, unless a same-cycle claim is re-setting it.
- WB_BYPASS_EN undefined:
  - Read ports return the array contents only; the new value is visible from the cycle after E1.
  - busy is reported as held until E1.

## Structure
- Package ysyx_20020207_wb_pkg holds:
  - The XLEN and REG_NUM constants.
  - The FSM state enum {WB_INIT, WB_RUN}.
  - The wb stage record typedef {valid, wen, addr, data}.
- One sub-module, ysyx_20020207_regfile, holds:
  - The array.
  - One write port.
  - Two asynchronous read ports with x0 forced to zero.
- Bypass muxing and the scoreboard stay in the top level.

## Test plan
- Sweep:
  - Stimulus: reset, then hold in_valid=1.
  - Required: in_ready=0 for 32 cycles, and no beat is accepted. Afterwards every register reads 0.
- Basic write:
  - Stimulus: beat result=0xDEADBEEF, reg_wen=1, reg_addr=5.
  - Required: retire pulses once, retire_count=1, and rs1_addr=5 reads 0xDEADBEEF.
  - Read timing: from E1+ with WB_BYPASS_EN undefined; from E0+ with it defined.
- x0 and no-write:
  - Stimulus: beat to reg_addr=0 with 0x1234, then a beat with reg_wen=0 to reg_addr=7.
  - Required: x0 still reads 0, x7 is unchanged, and retire_count advances by 2.
- Scoreboard:
  - Stimulus: claim x9, then a beat to x9.
  - Required: rs2_busy=1 until the clear edge, then 0.
  - Stimulus: claim x9 in the same cycle as the wb clear.
  - Required: busy stays 1.
- Back-to-back and reset:
  - Stimulus: beats 1, 2, 3 to x3 on consecutive cycles.
  - Required: x3 ends at 3 and retire_count=3.
  - Stimulus: assert reset with a beat in the wb stage.
  - Required: retire=0, retire_count=0, and the sweep restarts.
